// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall / taken-branch flush controller for a 5-stage pipeline
module hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CW              = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   if_id_instr,
  input  logic [2:0]    id_ex_mem,
  input  logic [4:0]    id_ex_rt,
  input  logic          mem_branch_taken,
  input  logic          cnt_clr,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          id_ex_bubble,
  output logic          if_id_flush,
  output logic          id_ex_flush,
  output logic          ex_mem_flush,
  output logic          stall_active,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  localparam logic RUN   = 1'b0;
  localparam logic STALL = 1'b1;

  // The first bubble is issued from RUN, so STALL covers the remaining LU_STALL_CYCLES-1.
  localparam logic       MULTI    = (LU_STALL_CYCLES > 1);
  localparam logic [3:0] REM_INIT = 4'((LU_STALL_CYCLES > 1) ? (LU_STALL_CYCLES - 2) : 0);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          state_q, state_d;
  logic [3:0]    rem_q, rem_d;
  logic [CW-1:0] stall_count_q, stall_count_d;
  logic [CW-1:0] flush_count_q, flush_count_d;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       uses_rt;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;

  // Decode: does the instruction in ID read the register a load in EX is about to write?
  always_comb begin
    opcode   = if_id_instr[31:26];
    rs       = if_id_instr[25:21];
    rt       = if_id_instr[20:16];
    uses_rt  = (opcode == 6'b000000) || (opcode == 6'b101011) || (opcode == 6'b000100);
    load_use = id_ex_mem[1] && (id_ex_rt != 5'd0) &&
               ((id_ex_rt == rs) || (uses_rt && (id_ex_rt == rt)));
  end

  // FSM next state and pipeline control; a taken branch always beats a stall.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    stall_active = 1'b0;

    if (mem_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      flush_inc    = 1'b1;
      state_d      = RUN;
      rem_d        = 4'd0;
    end else if ((state_q == STALL) || load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_active = 1'b1;
      stall_inc    = 1'b1;
      if (state_q == RUN) begin
        if (MULTI) begin
          state_d = STALL;
          rem_d   = REM_INIT;
        end
      end else if (rem_q == 4'd0) begin
        state_d = RUN;
      end else begin
        rem_d = rem_q - 4'd1;
      end
    end

    // Reset holds the pipeline frozen with a bubble in ID/EX.
    if (!rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      stall_active = 1'b0;
    end
  end

  // Saturating performance counters; clear wins over a same-cycle increment.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (cnt_clr) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall_inc && (stall_count_q != CNT_MAX)) stall_count_d = stall_count_q + CW'(1);
      if (flush_inc && (flush_count_q != CNT_MAX)) flush_count_d = flush_count_q + CW'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      rem_q         <= 4'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
